// File: rtl/popcount_pipe.sv
// popcount_pipe: fully pipelined population counter.
//   Counts the ones in a WIDTH-bit word through a registered adder tree
//   (one register level per tree level, LVL = log2(WIDTH) levels), so one
//   word per cycle goes in and the result appears LVL edges later.
//   A side-band shift register carries valid/mode/threshold alongside the
//   tree. A saturating accumulator sums counts of mode=1 results.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid            qualifies in_data/in_mode/in_thr this cycle
//   in_data [WIDTH]     word to count
//   in_mode             0 = count only, 1 = count and accumulate
//   in_thr  [CNT_W]     threshold compared against this word's count
//   acc_clear           synchronous accumulator clear
//   out_valid           one-cycle result pulse per input word
//   out_count [CNT_W]   number of ones in the word
//   out_ge              out_count >= threshold of the same word
//   acc_value [ACC_W]   saturating running total
//   acc_sat             sticky saturation flag

// One tree node: registered sum of two IW-bit partial sums, IW+1 bits out.
module popcount_node #(
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] a,
  input  logic [IW-1:0] b,
  output logic [IW:0]   sum
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= '0;
    else     sum <= {1'b0, a} + {1'b0, b};
  end
endmodule

module popcount_pipe #(
  parameter  int WIDTH = 32,           // power of two, 2..256
  parameter  int ACC_W = 16,           // must be >= CNT_W
  localparam int LVL   = $clog2(WIDTH),
  localparam int CNT_W = LVL + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [CNT_W-1:0] in_thr,
  input  logic             acc_clear,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ge,
  output logic [ACC_W-1:0] acc_value,
  output logic             acc_sat
);

  // All tree levels live in one flat vector. Level k holds WIDTH>>k partial
  // sums of k+1 bits each; lvl_off(k) is the bit offset where level k starts.
  // Level 0 is the raw input word.
  function automatic int lvl_off(input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += (WIDTH >> j) * (j + 1);
    return o;
  endfunction

  localparam int TREE_W = lvl_off(LVL + 1);
  localparam int FIN    = lvl_off(LVL);

  logic [TREE_W-1:0] tree;

  assign tree[WIDTH-1:0] = in_data;

  // Data registers load every cycle regardless of valid; only the output
  // valid and the accumulator look at the carried valid bit.
  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    for (genvar i = 0; i < (WIDTH >> k); i++) begin : g_node
      localparam int SRC = lvl_off(k - 1) + 2 * i * k;
      localparam int DST = lvl_off(k) + i * (k + 1);
      popcount_node #(.IW(k)) u_node (
        .clk (clk),
        .rst (rst),
        .a   (tree[SRC +: k]),
        .b   (tree[SRC + k +: k]),
        .sum (tree[DST +: k + 1])
      );
    end
  end

  assign out_count = tree[FIN +: CNT_W];

  // Side-band pipe, stage s aligned with tree level s.
  logic [LVL:1]            vld_pipe;
  logic [LVL:1]            mode_pipe;
  logic [LVL:1][CNT_W-1:0] thr_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      mode_pipe <= '0;
      // All-ones exceeds any count, so out_ge reads 0 out of reset.
      thr_pipe  <= '1;
    end else begin
      vld_pipe[1]  <= in_valid;
      mode_pipe[1] <= in_mode;
      thr_pipe[1]  <= in_thr;
      for (int s = 2; s <= LVL; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        mode_pipe[s] <= mode_pipe[s-1];
        thr_pipe[s]  <= thr_pipe[s-1];
      end
    end
  end

  assign out_valid = vld_pipe[LVL];
  assign out_ge    = (out_count >= thr_pipe[LVL]);

  // Accumulator: one spare bit detects overflow before clamping. A clear in
  // the same cycle as an update zeroes the base first, then adds.
  logic             acc_upd;
  logic [ACC_W:0]   acc_base;
  logic [ACC_W:0]   acc_sum;

  assign acc_upd  = out_valid & mode_pipe[LVL];
  assign acc_base = acc_clear ? '0 : {1'b0, acc_value};
  assign acc_sum  = acc_base + {{(ACC_W + 1 - CNT_W){1'b0}}, out_count};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_value <= '0;
      acc_sat   <= 1'b0;
    end else if (acc_upd) begin
      acc_value <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      acc_sat   <= (acc_sat & ~acc_clear) | acc_sum[ACC_W];
    end else if (acc_clear) begin
      acc_value <= '0;
      acc_sat   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench for popcount_pipe: three instances share clock and reset.
//   dut   WIDTH=32 ACC_W=16   main function
//   dut_a WIDTH=32 ACC_W=8    same inputs as dut, exercises saturation
//   dut_w WIDTH=8  ACC_W=4    random words against a reference model
module tb_popcount_pipe;
  localparam int LVL = 5;
  localparam int WL  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 0, in_mode = 0, acc_clear = 0;
  logic [31:0] in_data = 0;
  logic [5:0]  in_thr = 0;
  logic        out_valid, out_ge, acc_sat;
  logic [5:0]  out_count;
  logic [15:0] acc_value;
  logic        a_valid, a_ge, a_sat;
  logic [5:0]  a_count;
  logic [7:0]  a_acc;

  logic        w_in_valid = 0, w_in_mode = 0, w_clear = 0;
  logic [7:0]  w_in_data = 0;
  logic [3:0]  w_in_thr = 0;
  logic        w_valid, w_ge, w_sat;
  logic [3:0]  w_count, w_acc;

  int pass_cnt = 0;
  int total    = 0;

  popcount_pipe #(.WIDTH(32), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_mode(in_mode), .in_thr(in_thr), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_count(out_count), .out_ge(out_ge),
    .acc_value(acc_value), .acc_sat(acc_sat));

  popcount_pipe #(.WIDTH(32), .ACC_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_mode(in_mode), .in_thr(in_thr), .acc_clear(acc_clear),
    .out_valid(a_valid), .out_count(a_count), .out_ge(a_ge),
    .acc_value(a_acc), .acc_sat(a_sat));

  popcount_pipe #(.WIDTH(8), .ACC_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_data(w_in_data),
    .in_mode(w_in_mode), .in_thr(w_in_thr), .acc_clear(w_clear),
    .out_valid(w_valid), .out_count(w_count), .out_ge(w_ge),
    .acc_value(w_acc), .acc_sat(w_sat));

  task automatic drv(input logic v, input logic [31:0] d, input logic m,
                     input logic [5:0] t);
    in_valid = v; in_data = d; in_mode = m; in_thr = t;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0d want 0", out_valid); else pass_cnt++;
    total++; if (out_count !== 6'd0) $display("FAIL rst_count got %0d want 0", out_count); else pass_cnt++;
    total++; if (out_ge !== 1'b0) $display("FAIL rst_ge got %0d want 0", out_ge); else pass_cnt++;
    total++; if (acc_value !== 16'd0) $display("FAIL rst_acc got %0d want 0", acc_value); else pass_cnt++;
    total++; if (acc_sat !== 1'b0) $display("FAIL rst_sat got %0d want 0", acc_sat); else pass_cnt++;
    total++; if ({w_valid, w_count, w_ge, w_acc, w_sat} !== 11'd0)
      $display("FAIL rst_w8 got %h want 0", {w_valid, w_count, w_ge, w_acc, w_sat}); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk); drv(1, 32'hFFFF_FFFF, 0, 6'd32);
    for (int c = 1; c <= LVL + 3; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== (c == LVL)) $display("FAIL single_valid c=%0d got %0d want %0d", c, out_valid, (c == LVL));
      else pass_cnt++;
      if (c == LVL) begin
        total++; if (out_count !== 6'd32) $display("FAIL single_count got %0d want 32", out_count); else pass_cnt++;
        total++; if (out_ge !== 1'b1) $display("FAIL single_ge got %0d want 1", out_ge); else pass_cnt++;
      end
      drv(0, 0, 0, 0);
    end
    total++; if (acc_value !== 16'd0) $display("FAIL single_acc got %0d want 0", acc_value); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [5] = '{32'h0, 32'h8000_0001, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h1234_5678};
    logic        vld   [5] = '{1, 1, 1, 0, 1};
    logic [5:0]  ecnt  [5] = '{0, 2, 16, 0, 13};
    logic        ege   [5] = '{0, 0, 1, 0, 1};
    for (int c = 0; c <= 5 + LVL; c++) begin
      @(negedge clk);
      if (c >= LVL) begin
        int j = c - LVL;
        logic ev = (j < 5) ? vld[j] : 1'b0;
        total++;
        if (out_valid !== ev) $display("FAIL b2b_valid slot=%0d got %0d want %0d", j, out_valid, ev);
        else pass_cnt++;
        if (ev) begin
          total++; if (out_count !== ecnt[j]) $display("FAIL b2b_count slot=%0d got %0d want %0d", j, out_count, ecnt[j]); else pass_cnt++;
          total++; if (out_ge !== ege[j]) $display("FAIL b2b_ge slot=%0d got %0d want %0d", j, out_ge, ege[j]); else pass_cnt++;
        end
      end
      if (c < 5) drv(vld[c], words[c], 0, 6'd13); else drv(0, 0, 0, 0);
    end
  endtask

  task automatic test_acc_sat;
    @(negedge clk); acc_clear = 1'b1; drv(0, 0, 0, 0);
    for (int c = 0; c <= 9 + LVL + 1; c++) begin
      @(negedge clk);
      acc_clear = 1'b0;
      if (c - LVL - 1 >= 0 && c - LVL - 1 < 9) begin
        int j = c - LVL - 1;
        int e = 32 * (j + 1);
        int e8 = (e > 255) ? 255 : e;
        total++; if (a_acc !== 8'(e8)) $display("FAIL sat_acc8 word=%0d got %0d want %0d", j, a_acc, e8); else pass_cnt++;
        total++; if (a_sat !== (j >= 7)) $display("FAIL sat_flag8 word=%0d got %0d want %0d", j, a_sat, (j >= 7)); else pass_cnt++;
        total++; if (acc_value !== 16'(e)) $display("FAIL sat_acc16 word=%0d got %0d want %0d", j, acc_value, e); else pass_cnt++;
      end
      if (c < 9) drv(1, 32'hFFFF_FFFF, 1, 0); else drv(0, 0, 0, 0);
    end
  endtask

  task automatic test_acc_clear;
    @(negedge clk); drv(1, 32'h7F, 1, 0);
    repeat (LVL - 1) begin @(negedge clk); drv(0, 0, 0, 0); end
    @(negedge clk);
    total++; if (a_valid !== 1'b1 || a_count !== 6'd7) $display("FAIL clr_result got v=%0d c=%0d want v=1 c=7", a_valid, a_count); else pass_cnt++;
    acc_clear = 1'b1;
    @(negedge clk); acc_clear = 1'b0;
    total++; if (a_acc !== 8'd7) $display("FAIL clr_add_acc8 got %0d want 7", a_acc); else pass_cnt++;
    total++; if (a_sat !== 1'b0) $display("FAIL clr_add_sat8 got %0d want 0", a_sat); else pass_cnt++;
    total++; if (acc_value !== 16'd7) $display("FAIL clr_add_acc16 got %0d want 7", acc_value); else pass_cnt++;
    // mode=0 result must leave the total alone
    drv(1, 32'hFF, 0, 0);
    repeat (LVL + 1) begin @(negedge clk); drv(0, 0, 0, 0); end
    total++; if (a_acc !== 8'd7) $display("FAIL mode0_acc8 got %0d want 7", a_acc); else pass_cnt++;
    acc_clear = 1'b1;
    @(negedge clk); acc_clear = 1'b0;
    total++; if (a_acc !== 8'd0) $display("FAIL clr_only_acc8 got %0d want 0", a_acc); else pass_cnt++;
    total++; if (acc_value !== 16'd0) $display("FAIL clr_only_acc16 got %0d want 0", acc_value); else pass_cnt++;
  endtask

  task automatic test_reset_midflight;
    logic bad;
    for (int c = 0; c < 7; c++) begin @(negedge clk); drv(1, 32'hFFFF_FFFF, 1, 6'd10); end
    @(negedge clk); drv(0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || acc_value === 16'd0)
      $display("FAIL mid_pre got v=%0d acc=%0d want v=1 acc>0", out_valid, acc_value); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total++; if ({out_valid, out_count, out_ge, acc_value, acc_sat} !== 25'd0)
      $display("FAIL mid_rst_outputs got %h want 0", {out_valid, out_count, out_ge, acc_value, acc_sat}); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    bad = 1'b0;
    repeat (12) begin @(negedge clk); if (out_valid !== 1'b0) bad = 1'b1; end
    total++; if (bad) $display("FAIL mid_spurious_valid got 1 want 0"); else pass_cnt++;
    drv(1, 32'h3, 0, 6'd2);
    repeat (LVL - 1) begin @(negedge clk); drv(0, 0, 0, 0); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) $display("FAIL mid_new_valid got %0d want 1", out_valid); else pass_cnt++;
    total++; if (out_count !== 6'd2) $display("FAIL mid_new_count got %0d want 2", out_count); else pass_cnt++;
    total++; if (out_ge !== 1'b1) $display("FAIL mid_new_ge got %0d want 1", out_ge); else pass_cnt++;
  endtask

  task automatic test_w8_random;
    localparam int N = 1000;
    logic       sv [N];
    logic       sm [N];
    logic [3:0] scnt [N];
    logic       sge  [N];
    logic       clr  [N + 8];
    logic [3:0] macc;
    logic       msat;
    macc = 0; msat = 0;
    for (int c = 0; c <= N + 4; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        int j = c - WL - 1;
        logic cl = clr[c-1];
        if (j >= 0 && j < N && sv[j] && sm[j]) begin
          int s = (cl ? 0 : int'(macc)) + int'(scnt[j]);
          logic bs = cl ? 1'b0 : msat;
          if (s > 15) begin macc = 4'hF; msat = 1'b1; end
          else begin macc = 4'(s); msat = bs; end
        end else if (cl) begin
          macc = 0; msat = 0;
        end
        total++; if (w_acc !== macc || w_sat !== msat)
          $display("FAIL w8_acc c=%0d got %0d/%0d want %0d/%0d", c, w_acc, w_sat, macc, msat); else pass_cnt++;
      end
      if (c >= WL) begin
        int j = c - WL;
        logic ev = (j < N) ? sv[j] : 1'b0;
        total++; if (w_valid !== ev) $display("FAIL w8_valid slot=%0d got %0d want %0d", j, w_valid, ev); else pass_cnt++;
        if (ev) begin
          total++; if (w_count !== scnt[j] || w_ge !== sge[j])
            $display("FAIL w8_count slot=%0d got %0d/%0d want %0d/%0d", j, w_count, w_ge, scnt[j], sge[j]); else pass_cnt++;
        end
      end
      if (c < N) begin
        int r = $urandom_range(0, 7);
        logic [7:0] d = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
        logic [3:0] t = 4'($urandom_range(0, 15));
        sv[c] = ($urandom_range(0, 3) != 0);
        sm[c] = 1'($urandom_range(0, 1));
        scnt[c] = 4'($countones(d));
        sge[c] = (int'(scnt[c]) >= int'(t));
        clr[c] = ($urandom_range(0, 15) == 0);
        w_in_valid = sv[c]; w_in_data = d; w_in_mode = sm[c]; w_in_thr = t; w_clear = clr[c];
      end else begin
        clr[c] = 1'b0;
        w_in_valid = 0; w_in_data = 0; w_in_mode = 0; w_in_thr = 0; w_clear = 0;
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_acc_sat;
    test_acc_clear;
    test_reset_midflight;
    test_w8_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
